// File: rtl/mult_pipe_hs.sv
// -----------------------------------------------------------------------------
// mult_pipe_hs
// Stallable pipelined integer multiplier, WIDTH x WIDTH -> 2*WIDTH, with a
// valid/ready handshake on both sides and a synchronous flush. Signed or
// unsigned mode is chosen per beat and travels down the pipe with its beat.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-high reset
//   flush      synchronous flush; drops every in-flight beat
//   in_valid   a, b, is_signed carry a beat this cycle
//   in_ready   block accepts a beat this cycle
//   a, b       operands (WIDTH bits)
//   is_signed  1 = both operands two's complement, 0 = both unsigned
//   out_valid  result carries a beat
//   out_ready  consumer takes the result this cycle
//   result     full 2*WIDTH product
//   in_flight  number of valid beats held in the pipeline (0..STAGES)
//
// The pipe is a lock-step shift: every stage moves when adv is high, bubbles
// included, so latency is always STAGES cycles plus any stall cycles.
// -----------------------------------------------------------------------------
module mult_pipe_hs #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [3:0]         in_flight
);

    localparam int PW = 2 * WIDTH;

    logic              adv;
    logic              accept;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;

    // Extending both operands to the full product width makes a single
    // truncated multiply correct for signed and unsigned alike.
    function automatic logic [PW-1:0] mul_ext(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             sgn);
        logic [PW-1:0] xe;
        logic [PW-1:0] ye;
        xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        return xe * ye;
    endfunction

    function automatic logic [3:0] count_ones(input logic [STAGES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < STAGES; i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

    assign out_valid = vld_q[STAGES-1];
    assign adv       = ~out_valid | out_ready;
    // clr term keeps in_ready low during reset even though adv is high then.
    assign in_ready  = adv & ~flush & ~clr;
    assign accept    = in_valid & in_ready;

    // flush wins over a stall: valid bits clear whether or not adv is high.
    always_comb begin
        vld_d = vld_q;
        if (flush) begin
            vld_d = '0;
        end else if (adv) begin
            vld_d[0] = accept;
            for (int i = 1; i < STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vld_q     <= '0;
            in_flight <= '0;
        end else begin
            vld_q     <= vld_d;
            in_flight <= count_ones(vld_d);
        end
    end

    // Data registers only load behind a valid beat; stale contents under a
    // cleared valid bit are never observed.
    if (STAGES == 1) begin : g_one
        logic [PW-1:0] prod_q;

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                prod_q <= '0;
            end else if (accept) begin
                prod_q <= mul_ext(a, b, is_signed);
            end
        end

        assign result = prod_q;
    end else begin : g_multi
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic             sgn_q;
        // prod_q[i] sits alongside vld_q[i]
        logic [PW-1:0]    prod_q [1:STAGES-1];

        always_ff @(posedge clk or posedge clr) begin
            if (clr) begin
                a_q   <= '0;
                b_q   <= '0;
                sgn_q <= 1'b0;
                for (int i = 1; i < STAGES; i++) begin
                    prod_q[i] <= '0;
                end
            end else begin
                if (accept) begin
                    a_q   <= a;
                    b_q   <= b;
                    sgn_q <= is_signed;
                end
                if (adv & vld_q[0]) begin
                    prod_q[1] <= mul_ext(a_q, b_q, sgn_q);
                end
                for (int i = 2; i < STAGES; i++) begin
                    if (adv & vld_q[i-1]) begin
                        prod_q[i] <= prod_q[i-1];
                    end
                end
            end
        end

        assign result = prod_q[STAGES-1];
    end

endmodule
